// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle control FSM and the
// unified instruction/data memory port.
interface multicycle_control_if;
    logic mem_req;    // request active this cycle
    logic mem_we;     // 1 = write, 0 = read
    logic iord;       // address select: 0 = PC, 1 = ALUOut
    logic mem_ready;  // memory completes the current request this cycle

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle LEGv8 core. Sequences fetch, decode,
// execute, memory and write-back over one ALU and one memory port, with a
// wait-state timeout that traps into a sticky ERROR state.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  mem,
    input  logic [10:0]           opcode,
    input  logic                  zero,
    input  logic                  cond_true,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic [1:0]            pc_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            imm_sel,
    output logic                  reg2loc,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic [3:0]            state,
    output logic                  error
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BR_CBZ   = 4'd9,
        S_BR_COND  = 4'd10,
        S_BR_UNC   = 4'd11,
        S_ERROR    = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        OP_LDUR  = 3'd0,
        OP_STUR  = 3'd1,
        OP_RTYPE = 3'd2,
        OP_CBZ   = 3'd3,
        OP_BCOND = 3'd4,
        OP_B     = 3'd5,
        OP_BAD   = 3'd6
    } op_class_e;

    // Timeout fires when the counter reaches TIMEOUT-1 with memory still busy.
    localparam bit               TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT - 1);

    // Classify the instruction from IR[31:21].
    function automatic op_class_e decode_op(input logic [10:0] op);
        op_class_e cls;
        if (op == 11'b111_1100_0010) begin
            cls = OP_LDUR;
        end else if (op == 11'b111_1100_0000) begin
            cls = OP_STUR;
        end else if ((op == 11'b100_0101_1000) || (op == 11'b110_0101_1000) ||
                     (op == 11'b100_0101_0000) || (op == 11'b101_0101_0000)) begin
            cls = OP_RTYPE;
        end else if (op[10:3] == 8'b1011_0100) begin
            cls = OP_CBZ;
        end else if (op[10:3] == 8'b0101_0100) begin
            cls = OP_BCOND;
        end else if (op[10:5] == 6'b00_0101) begin
            cls = OP_B;
        end else begin
            cls = OP_BAD;
        end
        return cls;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_class_e        op_cls_s;
    logic             waiting_s;
    logic             timeout_s;

    assign op_cls_s  = decode_op(opcode);
    assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout_s = TO_EN && (cnt_q == TO_VAL);

    // Next-state selection, including the memory-wait timeout trap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ready)  state_d = S_DECODE;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op_cls_s)
                    OP_LDUR, OP_STUR: state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_R_EXEC;
                    OP_CBZ:           state_d = S_BR_CBZ;
                    OP_BCOND:         state_d = S_BR_COND;
                    OP_B:             state_d = S_BR_UNC;
                    default:          state_d = S_ERROR;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_cls_s == OP_LDUR) state_d = S_MEM_RD;
                else                     state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem.mem_ready)  state_d = S_MEM_WB;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem.mem_ready)  state_d = S_FETCH;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEM_WR;
            end
            S_MEM_WB, S_R_WB, S_BR_CBZ, S_BR_COND, S_BR_UNC: state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // Wait counter: restarts on each state change, counts busy memory cycles.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting_s && !mem.mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and wait-counter registers; reset aborts any instruction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath control decode from the current state (Moore, plus ready/flags).
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.iord    = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        imm_sel     = 2'b00;
        reg2loc     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        error       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = mem.mem_ready;
                pc_en       = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b11;
                if ((op_cls_s == OP_CBZ) || (op_cls_s == OP_BCOND)) imm_sel = 2'b01;
                else if (op_cls_s == OP_B)                          imm_sel = 2'b10;
                else                                                imm_sel = 2'b00;
                reg2loc = (op_cls_s == OP_STUR) || (op_cls_s == OP_CBZ);
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.iord    = 1'b1;
                reg2loc     = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_R_WB:     reg_write = 1'b1;
            S_BR_CBZ: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                reg2loc   = 1'b1;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_BR_COND: begin
                pc_src = 2'b01;
                pc_en  = cond_true;
            end
            S_BR_UNC: begin
                pc_src = 2'b01;
                pc_en  = 1'b1;
            end
            S_ERROR:    error = 1'b1;
            default:    error = 1'b0;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control. For each instruction the model
// builds the expected per-cycle state trace from the instruction class and
// the planned memory wait lengths, then checks state and all control
// outputs every cycle.
module tb_multicycle_control;

    localparam int TO = 4;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DEC  = 4'd2,
                           ST_MADR = 4'd3,  ST_MRD   = 4'd4,  ST_MWB  = 4'd5,
                           ST_MWR  = 4'd6,  ST_REX   = 4'd7,  ST_RWB  = 4'd8,
                           ST_CBZ  = 4'd9,  ST_BCOND = 4'd10, ST_BUNC = 4'd11,
                           ST_ERR  = 4'd15;

    typedef enum int {C_LDUR, C_STUR, C_R, C_CBZ, C_BCOND, C_B, C_BAD} cls_e;
    typedef struct packed { logic [3:0] st; logic rdy; } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic        zero = 1'b0, cond_true = 1'b0;
    logic        ir_write, pc_en, reg2loc, reg_write, mem_to_reg, error;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, imm_sel;
    logic [3:0]  state;
    int          n_chk = 0, n_pass = 0;

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mem(bus.master), .opcode(opcode),
        .zero(zero), .cond_true(cond_true), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_sel(imm_sel), .reg2loc(reg2loc),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic cls_e classify(input logic [10:0] op);
        if (op == 11'b11111000010) return C_LDUR;
        if (op == 11'b11111000000) return C_STUR;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (op ==? 11'b10110100???) return C_CBZ;
        if (op ==? 11'b01010100???) return C_BCOND;
        if (op ==? 11'b000101?????) return C_B;
        return C_BAD;
    endfunction

    // Packing: {mem_req, mem_we, iord, ir_write, pc_en, pc_src, a, b, op, imm, r2l, rw, m2r, err}
    function automatic logic [31:0] exp_out(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic c, input logic [10:0] op);
        logic mr = 1'b0, we = 1'b0, io = 1'b0, irw = 1'b0, pce = 1'b0;
        logic r2l = 1'b0, rw = 1'b0, m2r = 1'b0, er = 1'b0;
        logic [1:0] ps = 2'b00, a = 2'b00, b = 2'b00, ao = 2'b00, imm = 2'b00;
        cls_e cl = classify(op);
        case (st)
            ST_FETCH: begin mr = 1'b1; b = 2'b01; irw = rdy; pce = rdy; end
            ST_DEC: begin
                a = 2'b10; b = 2'b11;
                imm = (cl == C_CBZ || cl == C_BCOND) ? 2'b01 : (cl == C_B) ? 2'b10 : 2'b00;
                r2l = (cl == C_STUR || cl == C_CBZ);
            end
            ST_MADR:  begin a = 2'b01; b = 2'b10; end
            ST_MRD:   begin mr = 1'b1; io = 1'b1; end
            ST_MWB:   begin rw = 1'b1; m2r = 1'b1; end
            ST_MWR:   begin mr = 1'b1; we = 1'b1; io = 1'b1; r2l = 1'b1; end
            ST_REX:   begin a = 2'b01; ao = 2'b10; end
            ST_RWB:   rw = 1'b1;
            ST_CBZ:   begin a = 2'b01; ao = 2'b01; r2l = 1'b1; ps = 2'b01; pce = z; end
            ST_BCOND: begin ps = 2'b01; pce = c; end
            ST_BUNC:  begin ps = 2'b01; pce = 1'b1; end
            ST_ERR:   er = 1'b1;
            default:  er = 1'b0;
        endcase
        return {13'd0, mr, we, io, irw, pce, ps, a, b, ao, imm, r2l, rw, m2r, er};
    endfunction

    function automatic logic [31:0] obs_out();
        return {13'd0, bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_en, pc_src,
                alu_src_a, alu_src_b, alu_op, imm_sel, reg2loc, reg_write, mem_to_reg, error};
    endfunction

    // One cycle: drive inputs after the falling edge, then check.
    task automatic step(input logic [3:0] es, input logic rdy, input logic z, input logic c);
        @(negedge clk);
        bus.mem_ready = rdy; zero = z; cond_true = c;
        #1;
        chk_eq("state", {28'd0, state}, {28'd0, es});
        chk_eq("outs", obs_out(), exp_out(es, rdy, z, c, opcode));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_state", {28'd0, state}, 32'd0);
        chk_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk_eq("rst_outs", obs_out(), 32'd0);
        repeat (2) step(ST_IDLE, 1'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_eq("rel_state", {28'd0, state}, 32'd0);
    endtask

    // Append a memory-wait phase; returns 1 when it ends in a timeout.
    function automatic bit push_wait(inout ent_t q[$], input logic [3:0] st, input int w);
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) q.push_back('{st: st, rdy: 1'b0});
            q.push_back('{st: ST_ERR, rdy: 1'($urandom)});
            return 1'b1;
        end
        for (int i = 0; i < w; i++) q.push_back('{st: st, rdy: 1'b0});
        q.push_back('{st: st, rdy: 1'b1});
        return 1'b0;
    endfunction

    task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic z, input logic c);
        ent_t q[$];
        bit   bad;
        q = {};
        opcode = op;
        bad = push_wait(q, ST_FETCH, fw);
        if (!bad) begin
            q.push_back('{st: ST_DEC, rdy: 1'($urandom)});
            case (classify(op))
                C_LDUR: begin
                    q.push_back('{st: ST_MADR, rdy: 1'($urandom)});
                    if (!push_wait(q, ST_MRD, mw)) q.push_back('{st: ST_MWB, rdy: 1'($urandom)});
                end
                C_STUR: begin
                    q.push_back('{st: ST_MADR, rdy: 1'($urandom)});
                    bad = push_wait(q, ST_MWR, mw);
                end
                C_R: begin
                    q.push_back('{st: ST_REX, rdy: 1'($urandom)});
                    q.push_back('{st: ST_RWB, rdy: 1'($urandom)});
                end
                C_CBZ:   q.push_back('{st: ST_CBZ,   rdy: 1'($urandom)});
                C_BCOND: q.push_back('{st: ST_BCOND, rdy: 1'($urandom)});
                C_B:     q.push_back('{st: ST_BUNC,  rdy: 1'($urandom)});
                default: q.push_back('{st: ST_ERR,   rdy: 1'($urandom)});
            endcase
        end
        foreach (q[i]) step(q[i].st, q[i].rdy, z, c);
        if (q[q.size()-1].st == ST_ERR) begin
            // ERROR is sticky until reset.
            repeat (2) step(ST_ERR, 1'($urandom), z, c);
            do_reset();
        end
    endtask

    function automatic logic [10:0] pick_op();
        logic [10:0] r = 11'($urandom);
        logic [10:0] rt [4] = '{11'b10001011000, 11'b11001011000,
                                11'b10001010000, 11'b10101010000};
        case ($urandom_range(0, 7))
            0:       return 11'b11111000010;
            1:       return 11'b11111000000;
            2, 7:    return rt[$urandom_range(0, 3)];
            3:       return {8'b10110100, r[2:0]};
            4:       return {8'b01010100, r[2:0]};
            5:       return {6'b000101, r[4:0]};
            default: return r;
        endcase
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 15) == 0) return TO + int'($urandom_range(0, 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        do_reset();
        // Directed cases.
        run_instr(11'b11111000010, 0, 3, 1'b0, 1'b0);  // LDUR, 3 wait cycles in MEM_RD
        run_instr(11'b10110100101, 0, 0, 1'b1, 1'b0);  // CBZ taken
        run_instr(11'b10110100101, 0, 0, 1'b0, 1'b1);  // CBZ not taken
        run_instr(11'b11111000000, 1, 2, 1'b0, 1'b0);  // STUR
        run_instr(11'b10001011000, 3, 0, 1'b0, 1'b0);  // fetch ready on last allowed cycle
        run_instr(11'b01010100011, 0, 0, 1'b0, 1'b1);  // B.cond taken
        run_instr(11'b00010110101, 0, 0, 1'b0, 1'b0);  // B
        run_instr(11'b11111000010, 4, 0, 1'b0, 1'b0);  // fetch timeout -> ERROR
        run_instr(11'b11111111111, 0, 0, 1'b0, 1'b0);  // illegal opcode -> ERROR
        run_instr(11'b11111000000, 0, 4, 1'b0, 1'b0);  // MEM_WR timeout
        // Reset in the middle of a MEM_RD wait.
        opcode = 11'b11111000010;
        step(ST_FETCH, 1'b1, 1'b0, 1'b0);
        step(ST_DEC,   1'b0, 1'b0, 1'b0);
        step(ST_MADR,  1'b0, 1'b0, 1'b0);
        step(ST_MRD,   1'b0, 1'b0, 1'b0);
        do_reset();
        // Randomized instruction stream.
        for (int n = 0; n < 200; n++)
            run_instr(pick_op(), pick_wait(), pick_wait(), 1'($urandom), 1'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
